cal_fifo_ptr_sync: RTL and testbench

- Multi-channel, parametrised synchroniser for Gray-coded FIFO pointers crossing into the `clk` domain.
- Successor to the single-channel N-stage pointer sync. Adds:
  - channel count parameter
  - Gray-to-binary output
  - pipeline-fill valid flag
  - sticky per-channel Gray-step error detection
- Sits in CAL FIFO wrappers between the remote pointer register and the local full/empty logic.

---
 rtl/cal_ptr_sync_pkg.sv | 44 ++++
 rtl/cal_ptr_sync_chain.sv | 40 ++++
 rtl/cal_fifo_ptr_sync.sv | 140 ++++++++++++++
 tb/tb_cal_fifo_ptr_sync.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cal_ptr_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cal_ptr_sync_pkg
//  Description : Shared constants and helper functions for the CAL FIFO
//                Gray-pointer synchroniser (legal parameter ranges, Gray to
//                binary conversion, multi-bit-change detection).
//  Revision    : 1.0 - initial release
// ============================================================================
package cal_ptr_sync_pkg;

    localparam int MIN_STAGES = 2;
    localparam int MAX_STAGES = 8;
    localparam int MAX_CH     = 16;
    // Helpers operate on a fixed maximum width; callers zero-extend.
    localparam int MAX_PTR_W  = 32;

    // Gray to binary over the low w bits: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
    // Bits at or above w are masked off so they cannot pollute the prefix XOR.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(
        input logic [MAX_PTR_W-1:0] g,
        input int                   w
    );
        logic [MAX_PTR_W-1:0] m;
        logic [MAX_PTR_W-1:0] gm;
        logic [MAX_PTR_W-1:0] b;
        m  = '1;
        m  = m ^ (m << w);
        gm = g & m;
        b  = '0;
        b[MAX_PTR_W-1] = gm[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit
    // leaves something behind.
    function automatic logic popcount_gt1(input logic [MAX_PTR_W-1:0] x);
        return |(x & (x - MAX_PTR_W'(1)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cal_ptr_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : cal_ptr_sync_chain
//  Description : One channel's synchroniser: NUM_STAGES plain flops in
//                series, no logic between stages, synchronous reset.
//  Ports       : clk  - destination clock
//                srst - synchronous active-high reset
//                i_d  - asynchronous Gray pointer in
//                o_q  - last stage output
//  Revision    : 1.0 - initial release
// ============================================================================
module cal_ptr_sync_chain #(
    parameter int NUM_STAGES = 2,
    parameter int WIDTH      = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [NUM_STAGES];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_q = r_stage[NUM_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cal_fifo_ptr_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cal_fifo_ptr_sync
//  Description : Multi-channel Gray-pointer synchroniser into the clk domain
//                with Gray-to-binary output, pipeline-fill valid flag and
//                sticky per-channel illegal-Gray-step detection.
//  Ports       : clk        - sole clock
//                srst       - synchronous active-high reset
//                inp        - packed Gray pointers, channel c at [c*PW +: PW]
//                err_clr    - per-channel clear of the sticky step error
//                sync_gray  - synchronised Gray pointers (same packing)
//                sync_bin   - binary equivalent of sync_gray
//                sync_valid - chain holds only post-reset samples
//                step_err   - sticky: channel saw a multi-bit Gray change
//  Options     : CAL_PTR_SYNC_BIN_REG_EN - register sync_bin (and delay
//                sync_gray to match); valid asserts one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module cal_fifo_ptr_sync
    import cal_ptr_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int ADDRWIDTH  = 3,
    parameter int NUM_CH     = 1
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0] inp,
    input  logic [NUM_CH-1:0]               err_clr,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_gray,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] sync_bin,
    output logic                            sync_valid,
    output logic [NUM_CH-1:0]               step_err
);

    localparam int c_ptr_w   = ADDRWIDTH + 1;
    localparam int c_total_w = NUM_CH * c_ptr_w;
`ifdef CAL_PTR_SYNC_BIN_REG_EN
    localparam int c_fill_n  = NUM_STAGES + 1;
`else
    localparam int c_fill_n  = NUM_STAGES;
`endif
    localparam int                c_cnt_w    = $clog2(c_fill_n + 1);
    localparam logic [c_cnt_w-1:0] c_fill_tgt = c_cnt_w'(c_fill_n);

    if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
        $error("cal_fifo_ptr_sync: NUM_STAGES out of range 2..8");
    end
    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
        $error("cal_fifo_ptr_sync: NUM_CH out of range 1..16");
    end

    logic [c_total_w-1:0] w_chain_gray;
    logic [c_total_w-1:0] w_chain_bin;
    logic [c_total_w-1:0] r_prev;
    logic [c_cnt_w-1:0]   r_fill;
    logic                 r_valid_d;
    logic                 w_chk_en;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_jump;
        logic r_err;

        cal_ptr_sync_chain #(
            .NUM_STAGES (NUM_STAGES),
            .WIDTH      (c_ptr_w)
        ) u_chain (
            .clk  (clk),
            .srst (srst),
            .i_d  (inp[c*c_ptr_w +: c_ptr_w]),
            .o_q  (w_chain_gray[c*c_ptr_w +: c_ptr_w])
        );

        assign w_chain_bin[c*c_ptr_w +: c_ptr_w] =
            c_ptr_w'(gray2bin(MAX_PTR_W'(w_chain_gray[c*c_ptr_w +: c_ptr_w]), c_ptr_w));

        assign w_jump = popcount_gt1(MAX_PTR_W'(sync_gray[c*c_ptr_w +: c_ptr_w] ^
                                                r_prev[c*c_ptr_w +: c_ptr_w]));

        // Set has priority over a coincident clear.
        always_ff @(posedge clk) begin
            if (srst) begin
                r_err <= 1'b0;
            end else begin
                r_err <= (w_chk_en & w_jump) | (r_err & ~err_clr[c]);
            end
        end

        assign step_err[c] = r_err;
    end

`ifdef CAL_PTR_SYNC_BIN_REG_EN
    logic [c_total_w-1:0] r_sync_gray;
    logic [c_total_w-1:0] r_sync_bin;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_sync_gray <= '0;
            r_sync_bin  <= '0;
        end else begin
            r_sync_gray <= w_chain_gray;
            r_sync_bin  <= w_chain_bin;
        end
    end

    assign sync_gray = r_sync_gray;
    assign sync_bin  = r_sync_bin;
`else
    assign sync_gray = w_chain_gray;
    assign sync_bin  = w_chain_bin;
`endif

    // Saturating fill counter: valid once every output stage holds a
    // sample taken after reset release.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_fill <= '0;
        end else if (r_fill != c_fill_tgt) begin
            r_fill <= r_fill + c_cnt_w'(1);
        end
    end

    assign sync_valid = (r_fill == c_fill_tgt);

    // r_valid_d gates the very first valid cycle, whose prev value is the
    // reset zero rather than a real pointer.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_prev    <= '0;
            r_valid_d <= 1'b0;
        end else begin
            r_prev    <= sync_gray;
            r_valid_d <= sync_valid;
        end
    end

    assign w_chk_en = sync_valid & r_valid_d;

endmodule
`default_nettype wire

// File: tb/tb_cal_fifo_ptr_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cal_fifo_ptr_sync
//  Description : Self-checking bench for cal_fifo_ptr_sync (2 channels).
//                A sample-history model predicts every output each cycle;
//                literal checks pin the directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cal_fifo_ptr_sync;

    localparam int AW = 3;
    localparam int PW = AW + 1;
    localparam int NC = 2;
    localparam int TW = NC * PW;
`ifdef CAL_PTR_SYNC_BIN_REG_EN
    localparam int NS = 3;
    localparam int L  = NS + 1;
`else
    localparam int NS = 2;
    localparam int L  = NS;
`endif

    logic          clk;
    logic          srst;
    logic [TW-1:0] inp;
    logic [NC-1:0] err_clr;
    logic [TW-1:0] sync_gray;
    logic [TW-1:0] sync_bin;
    logic          sync_valid;
    logic [NC-1:0] step_err;

    cal_fifo_ptr_sync #(
        .NUM_STAGES (NS),
        .ADDRWIDTH  (AW),
        .NUM_CH     (NC)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .inp        (inp),
        .err_clr    (err_clr),
        .sync_gray  (sync_gray),
        .sync_bin   (sync_bin),
        .sync_valid (sync_valid),
        .step_err   (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_k;          // non-reset edges since reset
    logic [TW-1:0] m_hist[$];    // last L samples of inp
    logic [TW-1:0] e_gray;
    logic [TW-1:0] p_gray;
    bit            e_valid;
    bit            p_valid;
    logic [NC-1:0] e_err;

    function automatic logic [TW-1:0] model_bin(input logic [TW-1:0] g);
        logic [TW-1:0] r;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            for (int b = 0; b < (1 << PW); b++) begin
                if (PW'(b ^ (b >> 1)) == g[c*PW +: PW]) r[c*PW +: PW] = PW'(b);
            end
        end
        return r;
    endfunction

    initial begin
        m_k = 0; e_gray = '0; p_gray = '0; e_valid = 0; p_valid = 0; e_err = '0;
    end

    always @(posedge clk) begin
        if (srst) begin
            m_k = 0;
            m_hist.delete();
            e_gray = '0; p_gray = '0; e_valid = 0; p_valid = 0; e_err = '0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                logic [PW-1:0] d;
                bit            set;
                d   = e_gray[c*PW +: PW] ^ p_gray[c*PW +: PW];
                set = e_valid && p_valid && ($countones(d) > 1);
                e_err[c] = set | (e_err[c] & ~err_clr[c]);
            end
            p_gray  = e_gray;
            p_valid = e_valid;
            m_hist.push_back(inp);
            if (m_hist.size() > L) void'(m_hist.pop_front());
            if (m_k < 100000) m_k++;
            e_valid = (m_k >= L);
            e_gray  = e_valid ? m_hist[0] : '0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("sync_gray",  32'(sync_gray),  32'(e_gray));
            check("sync_bin",   32'(sync_bin),   32'(model_bin(e_gray)));
            check("sync_valid", 32'(sync_valid), 32'(e_valid));
            check("step_err",   32'(step_err),   32'(e_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rst, input logic [TW-1:0] d, input logic [NC-1:0] clr);
        srst = rst; inp = d; err_clr = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [PW-1:0] gray(input int v);
        return PW'(v ^ (v >> 1));
    endfunction

    int cnt [NC];

    initial begin
        srst = 1'b1; inp = '0; err_clr = '0;
        @(negedge clk);
        step(1'b1, TW'($urandom), '0);
        step(1'b1, TW'($urandom), '0);
        chk_on = 1'b1;

        // Reset release and fill latency.
        for (int i = 1; i <= L; i++) begin
            step(1'b0, {4'b0000, 4'b0110}, '0);
            if (i == L - 1) check("valid_before_fill", 32'(sync_valid), 32'd0);
        end
        check("valid_at_fill", 32'(sync_valid), 32'd1);
        check("gray_at_fill",  32'(sync_gray[3:0]), 32'h6);
        check("bin_at_fill",   32'(sync_bin[3:0]),  32'h4);
        step(1'b0, {4'b0000, 4'b0110}, '0);
        check("no_err_first_valid", 32'(step_err), 32'd0);

        // Gray walk on ch0 from 4 through the 15->0 wrap back to 4.
        for (int i = 4; i <= 20; i++) step(1'b0, {4'b0000, gray(i % 16)}, '0);
        repeat (L + 1) step(1'b0, {4'b0000, 4'b0110}, '0);
        check("walk_no_err", 32'(step_err), 32'd0);
        check("walk_end_bin", 32'(sync_bin[3:0]), 32'd4);

        // Illegal step on ch1.
        step(1'b0, {4'b0011, 4'b0110}, '0);
        repeat (L - 1) step(1'b0, {4'b0011, 4'b0110}, '0);
        check("err_not_yet", 32'(step_err), 32'd0);
        step(1'b0, {4'b0011, 4'b0110}, '0);
        check("err_ch1_set", 32'(step_err), 32'h2);

        // Clear coincident with a second illegal step: set wins.
        step(1'b0, {4'b0101, 4'b0110}, '0);
        repeat (L - 1) step(1'b0, {4'b0101, 4'b0110}, '0);
        step(1'b0, {4'b0101, 4'b0110}, 2'b10);
        check("set_beats_clr", 32'(step_err), 32'h2);
        step(1'b0, {4'b0101, 4'b0110}, 2'b10);
        check("clr_alone", 32'(step_err), 32'd0);

        // Set ch0 error, then reset mid-stream.
        repeat (L + 1) step(1'b0, {4'b0101, 4'b1001}, '0);
        check("err_ch0_set", 32'(step_err), 32'h1);
        step(1'b1, {4'b1110, 4'b0011}, '0);
        check("rst_gray",  32'(sync_gray),  32'd0);
        check("rst_bin",   32'(sync_bin),   32'd0);
        check("rst_valid", 32'(sync_valid), 32'd0);
        check("rst_err",   32'(step_err),   32'd0);
        for (int i = 1; i <= L + 3; i++) begin
            step(1'b0, {4'b1111, 4'b1010}, '0);
            if (i < L) check("refill_valid_low", 32'(sync_valid), 32'd0);
        end
        check("refill_valid", 32'(sync_valid), 32'd1);
        check("refill_no_err", 32'(step_err), 32'd0);

        // Randomised traffic: mostly legal Gray steps, occasional jumps,
        // clears and resets.
        cnt[0] = 12; cnt[1] = 10;   // binary of 1010 / 1111
        for (int n = 0; n < 600; n++) begin
            logic [TW-1:0] d;
            logic [NC-1:0] clr;
            logic          r;
            r = ($urandom_range(0, 99) < 2);
            for (int c = 0; c < NC; c++) begin
                int x;
                x = int'($urandom_range(0, 15));
                if (x < 7)       cnt[c] = (cnt[c] + 1) % 16;
                else if (x == 7) cnt[c] = int'($urandom_range(0, 15));
                d[c*PW +: PW] = gray(cnt[c]);
                clr[c] = ($urandom_range(0, 9) == 0);
            end
            step(r, d, clr);
        end

        step(1'b0, inp, '0);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
